coffee_recipe_seq: RTL and testbench

Parametrised successor to the fixed three-drink coffee FSM. It runs one of NUM_RECIPES recipes through up to NUM_STAGES dispensing stages. Per-stage durations come from a runtime-writable recipe table, and zero-duration stages are skipped. Adds abort, an invalid-selection error and a config port; it sits between the front-panel debounce logic and the valve drivers.

---
 rtl/coffee_pkg.sv | 45 ++++
 rtl/coffee_next_stage.sv | 26 ++
 rtl/coffee_recipe_seq.sv | 200 ++++++++++++++++++++
 tb/tb_coffee_recipe_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coffee_pkg.sv
// Shared types and reset-default recipe durations for the coffee recipe sequencer.
package coffee_pkg;

  typedef enum logic [2:0] {
    AGUA   = 3'd0,
    CAFE   = 3'd1,
    LECHE  = 3'd2,
    AZUCAR = 3'd3,
    CREMA  = 3'd4
  } stage_e;

  localparam int unsigned REC_ESPRESSO   = 0;
  localparam int unsigned REC_LATTE      = 1;
  localparam int unsigned REC_CAPPUCCINO = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } seq_state_e;

  // Reset-time duration in cycles; unlisted recipes and stages default to 0.
  function automatic longint unsigned default_dur(input int unsigned recipe,
                                                  input int unsigned stage,
                                                  input longint unsigned clk_hz);
    longint unsigned d;
    d = 0;
    case (recipe)
      REC_ESPRESSO: begin
        if (stage == 32'(AGUA)) d = 2 * clk_hz;
        else if (stage == 32'(CAFE)) d = clk_hz;
      end
      REC_LATTE: begin
        if (stage <= 32'(AZUCAR)) d = clk_hz;
      end
      REC_CAPPUCCINO: begin
        if (stage == 32'(AGUA)) d = 2 * clk_hz;
        else if (stage >= 32'(LECHE) && stage <= 32'(CREMA)) d = clk_hz;
      end
      default: d = 0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/coffee_next_stage.sv
// Priority search: first stage with nonzero duration strictly above from_idx (or from -1 when launch).
module coffee_next_stage #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned TIME_W     = 32,
  parameter int unsigned SW         = 3
) (
  input  logic                             launch,
  input  logic [SW-1:0]                    from_idx,
  input  logic [NUM_STAGES-1:0][TIME_W-1:0] row,
  output logic [SW-1:0]                    next_idx_c,
  output logic                             none_left_c
);

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    next_idx_c  = '0;
    none_left_c = 1'b1;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      if ((launch || (i > int'(from_idx))) && (row[i] != '0)) begin
        next_idx_c  = SW'(i);
        none_left_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/coffee_recipe_seq.sv
// Recipe-table driven coffee dispensing sequencer with abort and runtime config.
// Optional pause support is enabled by defining COFFEE_SEQ_PAUSE_EN.
module coffee_recipe_seq
  import coffee_pkg::*;
#(
  parameter  int unsigned CLK_HZ       = 50_000_000,
  parameter  int unsigned NUM_RECIPES  = 4,
  parameter  int unsigned NUM_STAGES   = 5,
  parameter  int unsigned TIME_W       = 32,
  parameter  int unsigned END_HOLD_CYC = 2 * CLK_HZ,
  localparam int unsigned RW           = $clog2(NUM_RECIPES),
  localparam int unsigned SW           = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [RW-1:0]         recipe_sel,
  input  logic                  abort,
  input  logic                  pause,
  input  logic                  cfg_we,
  input  logic [RW-1:0]         cfg_recipe,
  input  logic [SW-1:0]         cfg_stage,
  input  logic [TIME_W-1:0]     cfg_dur,
  output logic                  cfg_err,
  output logic                  busy,
  output logic                  stage_valid,
  output logic [SW-1:0]         stage_idx,
  output logic [NUM_STAGES-1:0] stage_onehot,
  output logic                  done,
  output logic                  done_pulse,
  output logic                  aborted
);

  localparam int unsigned EW = $clog2(END_HOLD_CYC + 1);

  seq_state_e                state, state_n;
  logic [SW-1:0]             stage, stage_n;
  logic [TIME_W-1:0]         timer, timer_n;
  logic [EW-1:0]             end_cnt, end_n;
  logic [RW-1:0]             rec, rec_n;
  logic                      start_q;
  logic [TIME_W-1:0]         dur_tbl [NUM_RECIPES][NUM_STAGES];

  logic                      start_edge, sel_ok, cfg_ok, wr_ok, wr_err;
  logic                      start_err, abort_take, hold, pause_act;
  logic [TIME_W-1:0]         dur_cur;
  logic [NUM_STAGES-1:0][TIME_W-1:0] rec_row, launch_row, search_row;
  logic [SW-1:0]             next_idx_c;
  logic                      none_left_c;

`ifdef COFFEE_SEQ_PAUSE_EN
  assign pause_act = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_act    = 1'b0;
`endif

  assign start_edge = start && !start_q;
  assign sel_ok     = 32'(recipe_sel) < NUM_RECIPES;
  assign cfg_ok     = (32'(cfg_recipe) < NUM_RECIPES) && (32'(cfg_stage) < NUM_STAGES);
  assign wr_ok      = cfg_we && (state == IDLE) && cfg_ok;
  assign wr_err     = cfg_we && !wr_ok;
  assign dur_cur    = dur_tbl[rec][stage];

  // Launch row sees a same-cycle table write so the brew uses the new value.
  always_comb begin
    for (int unsigned s = 0; s < NUM_STAGES; s++) begin
      rec_row[s]    = dur_tbl[rec][s];
      launch_row[s] = sel_ok ? dur_tbl[recipe_sel][s] : '0;
      if (wr_ok && (cfg_recipe == recipe_sel) && (32'(cfg_stage) == s)) launch_row[s] = cfg_dur;
    end
  end

  assign search_row = (state == IDLE) ? launch_row : rec_row;

  coffee_next_stage #(
    .NUM_STAGES (NUM_STAGES),
    .TIME_W     (TIME_W),
    .SW         (SW)
  ) u_next (
    .launch      (state == IDLE),
    .from_idx    (stage),
    .row         (search_row),
    .next_idx_c  (next_idx_c),
    .none_left_c (none_left_c)
  );

  always_comb begin
    state_n    = state;
    stage_n    = stage;
    timer_n    = timer;
    end_n      = end_cnt;
    rec_n      = rec;
    start_err  = 1'b0;
    abort_take = 1'b0;
    hold       = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge && !abort) begin
          if (sel_ok) begin
            rec_n   = recipe_sel;
            timer_n = '0;
            end_n   = '0;
            if (none_left_c) begin
              state_n = FINISH;
              stage_n = '0;
            end else begin
              state_n = RUN;
              stage_n = next_idx_c;
            end
          end else begin
            start_err = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_n    = IDLE;
          abort_take = 1'b1;
          stage_n    = '0;
          timer_n    = '0;
        end else if (pause_act) begin
          hold = 1'b1;
        end else if (timer == dur_cur - TIME_W'(1)) begin
          timer_n = '0;
          if (none_left_c) begin
            state_n = FINISH;
            stage_n = '0;
            end_n   = '0;
          end else begin
            stage_n = next_idx_c;
          end
        end else begin
          timer_n = timer + TIME_W'(1);
        end
      end
      FINISH: begin
        if (abort) begin
          state_n    = IDLE;
          abort_take = 1'b1;
          end_n      = '0;
        end else if (end_cnt == EW'(END_HOLD_CYC - 1)) begin
          state_n = IDLE;
          end_n   = '0;
        end else begin
          end_n = end_cnt + EW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Recipe table; reset reloads the factory defaults.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NUM_RECIPES; r++)
        for (int unsigned s = 0; s < NUM_STAGES; s++)
          dur_tbl[r][s] <= TIME_W'(default_dur(r, s, 64'(CLK_HZ)));
    end else if (wr_ok) begin
      dur_tbl[cfg_recipe][cfg_stage] <= cfg_dur;
    end
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      stage        <= '0;
      timer        <= '0;
      end_cnt      <= '0;
      rec          <= '0;
      start_q      <= 1'b0;
      cfg_err      <= 1'b0;
      busy         <= 1'b0;
      stage_valid  <= 1'b0;
      stage_idx    <= '0;
      stage_onehot <= '0;
      done         <= 1'b0;
      done_pulse   <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state        <= state_n;
      stage        <= stage_n;
      timer        <= timer_n;
      end_cnt      <= end_n;
      rec          <= rec_n;
      start_q      <= start;
      cfg_err      <= start_err || wr_err;
      busy         <= (state_n != IDLE);
      stage_valid  <= (state_n == RUN);
      stage_idx    <= (state_n == RUN) ? stage_n : '0;
      stage_onehot <= ((state_n == RUN) && !hold) ? (NUM_STAGES'(1) << stage_n) : '0;
      done         <= (state_n == FINISH);
      done_pulse   <= (state_n == FINISH) && (state != FINISH);
      aborted      <= abort_take;
    end
  end

endmodule

// File: tb/tb_coffee_recipe_seq.sv
// Directed bench for coffee_recipe_seq with CLK_HZ=10, END_HOLD_CYC=20.
module tb_coffee_recipe_seq;

  localparam int unsigned HOLD = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, abort = 1'b0, pause = 1'b0, cfg_we = 1'b0;
  logic [1:0]  recipe_sel = '0, cfg_recipe = '0;
  logic [2:0]  cfg_stage = '0;
  logic [31:0] cfg_dur = '0;
  logic        cfg_err, busy, stage_valid, done, done_pulse, aborted;
  logic [2:0]  stage_idx;
  logic [4:0]  stage_onehot;

  logic        start3 = 1'b0, zero_bit = 1'b0;
  logic [1:0]  sel3 = '0, zero_rw = '0;
  logic [2:0]  zero_sw = '0;
  logic [31:0] zero_dur = '0;
  logic        cfg_err3, busy3, sv3, done3, dp3, ab3;
  logic [2:0]  si3;
  logic [4:0]  oh3;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  coffee_recipe_seq #(.CLK_HZ(10), .NUM_RECIPES(4), .NUM_STAGES(5), .TIME_W(32), .END_HOLD_CYC(20)) dut (
    .clk(clk), .reset(reset), .start(start), .recipe_sel(recipe_sel), .abort(abort), .pause(pause),
    .cfg_we(cfg_we), .cfg_recipe(cfg_recipe), .cfg_stage(cfg_stage), .cfg_dur(cfg_dur),
    .cfg_err(cfg_err), .busy(busy), .stage_valid(stage_valid), .stage_idx(stage_idx),
    .stage_onehot(stage_onehot), .done(done), .done_pulse(done_pulse), .aborted(aborted));

  coffee_recipe_seq #(.CLK_HZ(10), .NUM_RECIPES(3), .NUM_STAGES(5), .TIME_W(32), .END_HOLD_CYC(20)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .recipe_sel(sel3), .abort(zero_bit), .pause(zero_bit),
    .cfg_we(zero_bit), .cfg_recipe(zero_rw), .cfg_stage(zero_sw), .cfg_dur(zero_dur),
    .cfg_err(cfg_err3), .busy(busy3), .stage_valid(sv3), .stage_idx(si3),
    .stage_onehot(oh3), .done(done3), .done_pulse(dp3), .aborted(ab3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected trace built from the per-stage durations given by the caller.
  task automatic check_brew(input string nm, input int sel, input int d0, input int d1,
                            input int d2, input int d3, input int d4, input bit hold_start);
    int d [5];
    d = '{d0, d1, d2, d3, d4};
    recipe_sel = 2'(sel);
    start = 1'b1;
    step();
    cfg_we = 1'b0;
    if (!hold_start) start = 1'b0;
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < d[s]; c++) begin
        chk({nm, " onehot"}, 32'(stage_onehot), 32'(1) << s);
        chk({nm, " idx"}, 32'(stage_idx), 32'(s));
        chk({nm, " valid"}, 32'(stage_valid), 32'(1));
        chk({nm, " done_in_run"}, 32'(done), 32'(0));
        step();
      end
    end
    for (int c = 0; c < int'(HOLD); c++) begin
      chk({nm, " done"}, 32'(done), 32'(1));
      chk({nm, " done_pulse"}, 32'(done_pulse), (c == 0) ? 32'(1) : 32'(0));
      chk({nm, " fin_onehot"}, 32'(stage_onehot), 32'(0));
      chk({nm, " fin_busy"}, 32'(busy), 32'(1));
      step();
    end
    chk({nm, " idle_busy"}, 32'(busy), 32'(0));
    chk({nm, " idle_done"}, 32'(done), 32'(0));
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  rec;
    logic [2:0]  stg;
    logic [31:0] dur;
    logic        exp_err;
  } cfg_vec_t;

  initial begin
    cfg_vec_t vecs [6];
    int active, zeros, exp_zeros;
    bit reached;

    vecs[0] = '{1'b1, 2'd0, 3'd5, 32'd9, 1'b1};
    vecs[1] = '{1'b1, 2'd0, 3'd7, 32'd9, 1'b1};
    vecs[2] = '{1'b0, 2'd0, 3'd5, 32'd9, 1'b0};
    vecs[3] = '{1'b1, 2'd3, 3'd3, 32'd5, 1'b0};
    vecs[4] = '{1'b1, 2'd3, 3'd6, 32'd1, 1'b1};
    vecs[5] = '{1'b1, 2'd3, 3'd0, 32'd0, 1'b0};

    // Reset state
    step(); step();
    chk("rst busy", 32'(busy), 0);
    chk("rst onehot", 32'(stage_onehot), 0);
    chk("rst flags", 32'({cfg_err, stage_valid, done, done_pulse, aborted}), 0);
    chk("rst idx", 32'(stage_idx), 0);
    reset = 1'b0;
    step();

    // Config write vectors in IDLE
    for (int i = 0; i < 6; i++) begin
      cfg_we = vecs[i].we; cfg_recipe = vecs[i].rec; cfg_stage = vecs[i].stg; cfg_dur = vecs[i].dur;
      step();
      cfg_we = 1'b0;
      chk($sformatf("cfgvec%0d err", i), 32'(cfg_err), 32'(vecs[i].exp_err));
      chk($sformatf("cfgvec%0d busy", i), 32'(busy), 0);
      step();
      chk($sformatf("cfgvec%0d err_clr", i), 32'(cfg_err), 0);
    end

    check_brew("espresso", 0, 20, 10, 0, 0, 0, 1'b0);
    step();
    check_brew("cappuccino", 2, 20, 0, 10, 10, 10, 1'b0);
    step();
    check_brew("row3", 3, 0, 0, 0, 5, 0, 1'b0);
    step();

    // Write during RUN is dropped
    recipe_sel = 2'd0; start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    cfg_we = 1'b1; cfg_recipe = 2'd3; cfg_stage = 3'd3; cfg_dur = 32'd7;
    step();
    cfg_we = 1'b0;
    chk("run_wr err", 32'(cfg_err), 1);
    chk("run_wr busy", 32'(busy), 1);
    step();
    chk("run_wr err_clr", 32'(cfg_err), 0);
    abort = 1'b1; step(); abort = 1'b0;
    chk("run_abort aborted", 32'(aborted), 1);
    chk("run_abort busy", 32'(busy), 0);
    step();
    chk("run_abort pulse", 32'(aborted), 0);
    check_brew("row3_kept", 3, 0, 0, 0, 5, 0, 1'b0);
    step();

    // Write and start in the same IDLE cycle: brew picks up CAFE=4
    cfg_we = 1'b1; cfg_recipe = 2'd3; cfg_stage = 3'd1; cfg_dur = 32'd4;
    check_brew("wr_start", 3, 0, 4, 0, 5, 0, 1'b0);
    step();

    // Latte abort at LECHE cycle 7, with a start edge in the same cycle
    recipe_sel = 2'd1; start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 27; k++) step();
    chk("latte leche", 32'(stage_onehot), 32'b00100);
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0;
    chk("latte aborted", 32'(aborted), 1);
    chk("latte busy", 32'(busy), 0);
    chk("latte valves", 32'(stage_onehot), 0);
    chk("latte done", 32'(done | done_pulse), 0);
    step();
    chk("latte no_restart", 32'(busy), 0);
    chk("latte pulse_clr", 32'(aborted), 0);
    for (int k = 0; k < 25; k++) begin
      chk("latte no_done", 32'(done | done_pulse), 0);
      step();
    end
    start = 1'b0; step();

    // Abort wins over a start edge in IDLE
    abort = 1'b1; start = 1'b1; recipe_sel = 2'd0;
    step();
    abort = 1'b0;
    chk("idle_abort busy", 32'(busy), 0);
    chk("idle_abort aborted", 32'(aborted), 0);
    step();
    chk("idle_abort dropped", 32'(busy), 0);
    start = 1'b0; step();

    // Start held high through the brew does not retrigger
    check_brew("held", 3, 0, 4, 0, 5, 0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("held no_restart", 32'(busy), 0);
    end
    start = 1'b0; step(); start = 1'b1; step();
    chk("held rearm busy", 32'(busy), 1);
    chk("held rearm cafe", 32'(stage_onehot), 32'b00010);
    start = 1'b0; abort = 1'b1; step(); abort = 1'b0;
    chk("held abort", 32'(busy), 0);
    step();

    // Invalid selection on a three-recipe instance
    sel3 = 2'd3; start3 = 1'b1; step();
    chk("inv err", 32'(cfg_err3), 1);
    chk("inv busy", 32'(busy3), 0);
    step();
    chk("inv err_clr", 32'(cfg_err3), 0);
    chk("inv busy_hold", 32'(busy3), 0);
    start3 = 1'b0; step();
    sel3 = 2'd2; start3 = 1'b1; step(); start3 = 1'b0;
    chk("inv3 valid_start", 32'(busy3), 1);
    chk("inv3 agua", 32'(oh3), 32'b00001);

    // Pause for 8 edges mid-AGUA of an espresso
`ifdef COFFEE_SEQ_PAUSE_EN
    exp_zeros = 8;
`else
    exp_zeros = 0;
`endif
    active = 0; zeros = 0; reached = 1'b0;
    recipe_sel = 2'd0; start = 1'b1; step(); start = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (stage_onehot == 5'b00010) begin
        reached = 1'b1;
        break;
      end
      if (stage_onehot == 5'b00001) active++;
      else if (stage_onehot == 5'b00000) zeros++;
      if (cyc == 5) pause = 1'b1;
      if (cyc == 13) pause = 1'b0;
      step();
    end
    pause = 1'b0;
    chk("pause reached_cafe", 32'(reached), 1);
    chk("pause agua_active", 32'(active), 32'd20);
    chk("pause valves_closed", 32'(zeros), 32'(exp_zeros));
    abort = 1'b1; step(); abort = 1'b0;
    chk("pause abort", 32'(aborted), 1);
    step();

    // Reset mid-brew restores defaults: row 3 all zero goes straight to FINISH
    recipe_sel = 2'd3; start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("prereset busy", 32'(busy), 1);
    reset = 1'b1; #1;
    chk("async reset busy", 32'(busy), 0);
    step(); reset = 1'b0; step();
    check_brew("row3_default", 3, 0, 0, 0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
